// File: rtl/ex_stage.sv
// Execute stage: ALU, destination select and branch resolution, registered into EX/MEM.
// Define EX_MULT_EN to add the iterative shift-add multiplier that stalls upstream while busy.
module ex_stage (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        Flush_In,
  input  logic        RegWriteEN_In,
  input  logic        Mem2RegSEL_In,
  input  logic        MemWriteEN_In,
  input  logic        Beq_In,
  input  logic        Bne_In,
  input  logic        RegDstSEL_In,
  input  logic [4:0]  ALUCtrl_In,
  input  logic [4:0]  ALUSrc_In,
  input  logic [31:0] RegData1_In,
  input  logic [31:0] RegData2_In,
  input  logic [31:0] PCAddr_In,
  input  logic [15:0] Imm_In,
  input  logic [4:0]  RTAddr_In,
  input  logic [4:0]  RDAddr_In,
  input  logic [4:0]  Shamt_In,
  output logic        RegWriteEN_Out,
  output logic        Mem2RegSEL_Out,
  output logic        MemWriteEN_Out,
  output logic [31:0] ALUResult_Out,
  output logic [31:0] StoreData_Out,
  output logic [4:0]  WriteAddr_Out,
  output logic        BranchTaken_Out,
  output logic [31:0] BranchTarget_Out,
  output logic        Stall_Out
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd6;
  localparam logic [4:0] OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SRL  = 5'd9;
  localparam logic [4:0] OP_SRA  = 5'd10;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] imm_sext;
  logic [31:0] alu_res;
  logic [31:0] result_sel;
  logic        br_taken;
  logic [31:0] br_target;
  logic [4:0]  wr_addr;
  logic        unused_alusrc;

  assign unused_alusrc = ALUSrc_In[4];
  assign imm_sext      = {{16{Imm_In[15]}}, Imm_In};
  assign op_a          = ALUSrc_In[2] ? {27'b0, Shamt_In} : RegData1_In;

  // Lowest set select bit wins when several immediate forms are requested.
  always_comb begin
    op_b = RegData2_In;
    if (ALUSrc_In[0])      op_b = imm_sext;
    else if (ALUSrc_In[1]) op_b = {16'b0, Imm_In};
    else if (ALUSrc_In[3]) op_b = {Imm_In, 16'b0};
  end

  always_comb begin
    alu_res = 32'b0;
    case (ALUCtrl_In)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {31'b0, op_a < op_b};
      OP_SLL:  alu_res = op_b << op_a[4:0];
      OP_SRL:  alu_res = op_b >> op_a[4:0];
      OP_SRA:  alu_res = $signed(op_b) >>> op_a[4:0];
      default: alu_res = 32'b0;
    endcase
  end

  assign br_taken  = (Beq_In & (RegData1_In == RegData2_In)) |
                     (Bne_In & (RegData1_In != RegData2_In));
  assign br_target = PCAddr_In + {imm_sext[29:0], 2'b00};
  assign wr_addr   = RegDstSEL_In ? RDAddr_In : RTAddr_In;

`ifdef EX_MULT_EN
  localparam logic [4:0] OP_MUL = 5'd11;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mul_state_e;

  mul_state_e  state_q;
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [5:0]  cnt_q;

  assign Stall_Out = RESET_N & ~Flush_In &
                     (((state_q == ST_IDLE) && (ALUCtrl_In == OP_MUL)) || (state_q == ST_BUSY));
  assign result_sel = (state_q == ST_DONE) ? acc_q : alu_res;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      acc_q    <= 32'b0;
      mcand_q  <= 32'b0;
      mplier_q <= 32'b0;
      cnt_q    <= 6'd0;
    end else if (Flush_In) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ALUCtrl_In == OP_MUL) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= 32'b0;
            cnt_q    <= 6'd0;
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= ST_DONE;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end
`else
  assign Stall_Out  = 1'b0;
  assign result_sel = alu_res;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      RegWriteEN_Out   <= 1'b0;
      Mem2RegSEL_Out   <= 1'b0;
      MemWriteEN_Out   <= 1'b0;
      ALUResult_Out    <= 32'b0;
      StoreData_Out    <= 32'b0;
      WriteAddr_Out    <= 5'd0;
      BranchTaken_Out  <= 1'b0;
      BranchTarget_Out <= 32'b0;
    end else if (Flush_In || Stall_Out) begin
      RegWriteEN_Out   <= 1'b0;
      Mem2RegSEL_Out   <= 1'b0;
      MemWriteEN_Out   <= 1'b0;
      ALUResult_Out    <= 32'b0;
      StoreData_Out    <= 32'b0;
      WriteAddr_Out    <= 5'd0;
      BranchTaken_Out  <= 1'b0;
      BranchTarget_Out <= 32'b0;
    end else begin
      RegWriteEN_Out   <= RegWriteEN_In;
      Mem2RegSEL_Out   <= Mem2RegSEL_In;
      MemWriteEN_Out   <= MemWriteEN_In;
      ALUResult_Out    <= result_sel;
      StoreData_Out    <= RegData2_In;
      WriteAddr_Out    <= wr_addr;
      BranchTaken_Out  <= br_taken;
      BranchTarget_Out <= br_target;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; multiplier checks are built when EX_MULT_EN is defined.
module tb_ex_stage;
  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        Flush_In;
  logic        RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Beq_In, Bne_In, RegDstSEL_In;
  logic [4:0]  ALUCtrl_In, ALUSrc_In;
  logic [31:0] RegData1_In, RegData2_In, PCAddr_In;
  logic [15:0] Imm_In;
  logic [4:0]  RTAddr_In, RDAddr_In, Shamt_In;
  logic        RegWriteEN_Out, Mem2RegSEL_Out, MemWriteEN_Out;
  logic [31:0] ALUResult_Out, StoreData_Out, BranchTarget_Out;
  logic [4:0]  WriteAddr_Out;
  logic        BranchTaken_Out;
  logic        Stall_Out;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK = ~CLOCK;

  ex_stage dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .Flush_In(Flush_In),
    .RegWriteEN_In(RegWriteEN_In), .Mem2RegSEL_In(Mem2RegSEL_In), .MemWriteEN_In(MemWriteEN_In),
    .Beq_In(Beq_In), .Bne_In(Bne_In), .RegDstSEL_In(RegDstSEL_In),
    .ALUCtrl_In(ALUCtrl_In), .ALUSrc_In(ALUSrc_In),
    .RegData1_In(RegData1_In), .RegData2_In(RegData2_In), .PCAddr_In(PCAddr_In),
    .Imm_In(Imm_In), .RTAddr_In(RTAddr_In), .RDAddr_In(RDAddr_In), .Shamt_In(Shamt_In),
    .RegWriteEN_Out(RegWriteEN_Out), .Mem2RegSEL_Out(Mem2RegSEL_Out), .MemWriteEN_Out(MemWriteEN_Out),
    .ALUResult_Out(ALUResult_Out), .StoreData_Out(StoreData_Out), .WriteAddr_Out(WriteAddr_Out),
    .BranchTaken_Out(BranchTaken_Out), .BranchTarget_Out(BranchTarget_Out), .Stall_Out(Stall_Out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    Flush_In = 0; RegWriteEN_In = 0; Mem2RegSEL_In = 0; MemWriteEN_In = 0;
    Beq_In = 0; Bne_In = 0; RegDstSEL_In = 0; ALUCtrl_In = 0; ALUSrc_In = 0;
    RegData1_In = 0; RegData2_In = 0; PCAddr_In = 0; Imm_In = 0;
    RTAddr_In = 0; RDAddr_In = 0; Shamt_In = 0;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

`ifdef EX_MULT_EN
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int   n;
    logic bub;
    ALUCtrl_In = 5'd11; ALUSrc_In = 0; RegData1_In = a; RegData2_In = b;
    RegWriteEN_In = 1; RegDstSEL_In = 1; RDAddr_In = 5'd12;
    chk({tag, "_stall_first"}, Stall_Out, 1);
    n = 0; bub = 1;
    while (Stall_Out === 1'b1 && n < 100) begin
      step();
      n++;
      if (ALUResult_Out !== 0 || RegWriteEN_Out !== 0) bub = 0;
    end
    chk({tag, "_stall_cycles"}, n, 33);
    chk({tag, "_bubbles"}, bub, 1);
    step();
    chk({tag, "_product"}, ALUResult_Out, exp);
    chk({tag, "_regwrite"}, RegWriteEN_Out, 1);
    chk({tag, "_waddr"}, WriteAddr_Out, 12);
  endtask
`endif

  logic [31:0] logic_exp [4];

  initial begin
    RESET_N = 0;
    clr();
    RegData1_In = 5; RegData2_In = 6; RegWriteEN_In = 1; RDAddr_In = 3; RegDstSEL_In = 1;
    step(); step();
    chk("reset_alu", ALUResult_Out, 0);
    chk("reset_rw", RegWriteEN_Out, 0);
    chk("reset_waddr", WriteAddr_Out, 0);
    chk("reset_stall", Stall_Out, 0);
    RESET_N = 1;

    clr();
    RegData1_In = 32'h7FFFFFFF; RegData2_In = 1; RegWriteEN_In = 1; RTAddr_In = 7; RDAddr_In = 9;
    step();
    chk("add_res", ALUResult_Out, 32'h80000000);
    chk("add_rw", RegWriteEN_Out, 1);
    chk("add_waddr_rt", WriteAddr_Out, 7);
    chk("add_store", StoreData_Out, 1);

    clr();
    ALUCtrl_In = 1; RegData1_In = 5; RegData2_In = 7; Mem2RegSEL_In = 1; MemWriteEN_In = 1;
    step();
    chk("sub_res", ALUResult_Out, 32'hFFFFFFFE);
    chk("sub_m2r", Mem2RegSEL_Out, 1);
    chk("sub_mw", MemWriteEN_Out, 1);

    logic_exp[0] = 32'h00F0000F; logic_exp[1] = 32'hFFF00FFF;
    logic_exp[2] = 32'hFF000FF0; logic_exp[3] = 32'h000FF000;
    for (int i = 0; i < 4; i++) begin
      clr();
      ALUCtrl_In = 5'(i + 2); RegData1_In = 32'hF0F000FF; RegData2_In = 32'h0FF00F0F;
      step();
      chk("logic_op", ALUResult_Out, logic_exp[i]);
    end

    clr();
    ALUCtrl_In = 6; ALUSrc_In = 5'b00001; RegData1_In = 32'hFFFFFFFF; Imm_In = 16'h0001;
    step();
    chk("slt_sext", ALUResult_Out, 1);
    ALUCtrl_In = 7; ALUSrc_In = 5'b00010;
    step();
    chk("sltu_zext", ALUResult_Out, 0);

    clr();
    RegData2_In = 32'h11; Imm_In = 16'hFFFF;
    ALUSrc_In = 5'b00011;
    step();
    chk("src_sext_wins", ALUResult_Out, 32'hFFFFFFFF);
    ALUSrc_In = 5'b01010;
    step();
    chk("src_zext_wins", ALUResult_Out, 32'h0000FFFF);
    ALUSrc_In = 5'b01000;
    step();
    chk("src_upper", ALUResult_Out, 32'hFFFF0000);
    ALUSrc_In = 5'b10000;
    step();
    chk("src_reserved", ALUResult_Out, 32'h11);

    clr();
    Beq_In = 1; ALUSrc_In = 5'b00001; RegData1_In = 32'h55; RegData2_In = 32'h55;
    PCAddr_In = 32'h100; Imm_In = 16'hFFFF;
    step();
    chk("beq_taken", BranchTaken_Out, 1);
    chk("beq_target", BranchTarget_Out, 32'hFC);
    Beq_In = 0; Bne_In = 1;
    step();
    chk("bne_not_taken", BranchTaken_Out, 0);
    chk("bne_target", BranchTarget_Out, 32'hFC);
    RegData2_In = 32'h56; Imm_In = 16'h0004;
    step();
    chk("bne_taken", BranchTaken_Out, 1);
    chk("bne_fwd_target", BranchTarget_Out, 32'h110);

    clr();
    ALUCtrl_In = 10; ALUSrc_In = 5'b00100; Shamt_In = 4; RegData1_In = 32'h1F;
    RegData2_In = 32'h80000000; RegDstSEL_In = 1; RDAddr_In = 9; RTAddr_In = 2;
    step();
    chk("sra_res", ALUResult_Out, 32'hF8000000);
    chk("waddr_rd", WriteAddr_Out, 9);
    ALUCtrl_In = 9;
    step();
    chk("srl_res", ALUResult_Out, 32'h08000000);
    ALUCtrl_In = 8; RegData2_In = 32'h3;
    step();
    chk("sll_res", ALUResult_Out, 32'h30);

    clr();
    ALUCtrl_In = 12; RegData1_In = 32'h1234; RegData2_In = 32'h5678; RegWriteEN_In = 1;
    step();
    chk("unused_op", ALUResult_Out, 0);

    clr();
    Flush_In = 1; RegData1_In = 1; RegData2_In = 1; RegWriteEN_In = 1; Beq_In = 1;
    step();
    chk("flush_alu", ALUResult_Out, 0);
    chk("flush_rw", RegWriteEN_Out, 0);
    chk("flush_br", BranchTaken_Out, 0);

    clr();
    RegData1_In = 10; RegData2_In = 20; RegWriteEN_In = 1; PCAddr_In = 32'h40;
    step();
    chk("pre_reset_alu", ALUResult_Out, 30);
    RESET_N = 0;
    #2;
    chk("async_reset_alu", ALUResult_Out, 0);
    chk("async_reset_rw", RegWriteEN_Out, 0);
    chk("async_reset_tgt", BranchTarget_Out, 0);
    #2;
    RESET_N = 1;

`ifdef EX_MULT_EN
    step();
    clr();
    run_mul("mul1", 32'd12345, 32'd6789, 32'd83810205);
    run_mul("mul2", 32'd3, 32'd5, 32'd15);
    clr();
    chk("after_mul_stall", Stall_Out, 0);
    step();
    chk("after_mul_rw", RegWriteEN_Out, 0);

    clr();
    ALUCtrl_In = 11; RegData1_In = 7; RegData2_In = 9; RegWriteEN_In = 1;
    for (int i = 0; i < 10; i++) step();
    chk("busy10_stall", Stall_Out, 1);
    Flush_In = 1;
    step();
    clr();
    RegData1_In = 3; RegData2_In = 4; RegWriteEN_In = 1;
    chk("flush_busy_stall", Stall_Out, 0);
    chk("flush_busy_bubble", ALUResult_Out, 0);
    chk("flush_busy_rw", RegWriteEN_Out, 0);
    step();
    chk("post_flush_add", ALUResult_Out, 7);

    clr();
    ALUCtrl_In = 11; RegData1_In = 7; RegData2_In = 9; RegWriteEN_In = 1;
    for (int i = 0; i < 5; i++) step();
    RESET_N = 0;
    #1;
    chk("reset_busy_stall", Stall_Out, 0);
    chk("reset_busy_alu", ALUResult_Out, 0);
    clr();
    RegData1_In = 2; RegData2_In = 3; RegWriteEN_In = 1;
    #1;
    RESET_N = 1;
    #1;
    chk("reset_busy_idle", Stall_Out, 0);
    step();
    chk("post_reset_add", ALUResult_Out, 5);
`else
    step();
    clr();
    ALUCtrl_In = 11; RegData1_In = 32'd12345; RegData2_In = 32'd6789; RegWriteEN_In = 1;
    chk("nomul_stall", Stall_Out, 0);
    step();
    chk("nomul_res", ALUResult_Out, 0);
    chk("nomul_rw", RegWriteEN_Out, 1);
    chk("nomul_stall_after", Stall_Out, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
